dds_cfg_ctrl: RTL and testbench

//   Configuration controller between the SPI slave byte interface and the two DDS channels.

---
 rtl/dds_cfg_ctrl.sv | 109 ++++++++++
 tb/tb_dds_cfg_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl: parses SPI command frames into shadow DDS registers, commits them atomically, serves readback bytes
module dds_cfg_ctrl #(
  parameter int FW_W = 32,
  parameter logic [FW_W-1:0] FW1_RST = FW_W'(2147483),
  parameter logic [FW_W-1:0] FW2_RST = FW_W'(2147483),
  parameter logic [FW_W-1:0] TRI_RST = FW_W'(154748364)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_byte,
  input  logic            frame_act,
  output logic [7:0]      tx_byte,
  output logic [FW_W-1:0] freq_word1,
  output logic [FW_W-1:0] freq_word2,
  output logic [FW_W-1:0] tri_sym2,
  output logic [1:0]      ch_en,
  output logic            commit_pulse
);
  typedef enum logic [1:0] {IDLE, CMD_WAIT, DATA, DONE} state_t;
  state_t state, state_n;
  logic act_q, rise, fall, cmd_rx, data_rx, last_rx, short_end, stat_clr;
  logic is_rd, wr_pend, commit, err_addr, err_short;
  logic [3:0] addr;
  logic [1:0] byte_cnt;
  logic [7:0] commit_cnt;
  logic [2:0] ctrl, ctrl_n;
  logic [FW_W-1:0] hold, rd_val, sh_fw1, sh_fw2, sh_tri, fw1_n, fw2_n, tri_n;
  assign rise = frame_act & ~act_q;
  assign fall = ~frame_act & act_q;
  assign cmd_rx = (state == CMD_WAIT) & rx_valid;
  assign data_rx = (state == DATA) & rx_valid;
  assign last_rx = data_rx & (byte_cnt == 2'd3);
  // a byte arriving with the falling edge is consumed before the frame is judged
  assign short_end = fall & ((state == CMD_WAIT) | ((state == DATA) & ~last_rx));
  assign stat_clr = fall & ((state == DONE) | last_rx) & is_rd & (addr == 4'd5);
  always_comb begin
    state_n = fall ? IDLE : (state == IDLE && rise) ? CMD_WAIT : cmd_rx ? DATA : last_rx ? DONE : state;
  end
  always_comb begin
    fw1_n = (wr_pend && addr == 4'd0) ? hold : sh_fw1;
    fw2_n = (wr_pend && addr == 4'd1) ? hold : sh_fw2;
    tri_n = (wr_pend && addr == 4'd2) ? hold : sh_tri;
    ctrl_n = (wr_pend && addr == 4'd3) ? hold[2:0] : ctrl;
    commit = wr_pend & ((addr == 4'd4) | ((addr < 4'd4) & ctrl_n[2]));
    rd_val = (rx_byte[3:0] == 4'd0) ? sh_fw1 :
             (rx_byte[3:0] == 4'd1) ? sh_fw2 :
             (rx_byte[3:0] == 4'd2) ? sh_tri :
             (rx_byte[3:0] == 4'd3) ? FW_W'(ctrl) :
             (rx_byte[3:0] == 4'd5) ? FW_W'({commit_cnt, 6'b0, err_addr, err_short}) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      wr_pend <= 1'b0;
      is_rd <= 1'b0;
      addr <= '0;
      byte_cnt <= '0;
      hold <= '0;
      tx_byte <= 8'h00;
      sh_fw1 <= FW1_RST;
      sh_fw2 <= FW2_RST;
      sh_tri <= TRI_RST;
      ctrl <= 3'b011;
      freq_word1 <= FW1_RST;
      freq_word2 <= FW2_RST;
      tri_sym2 <= TRI_RST;
      ch_en <= 2'b11;
      commit_pulse <= 1'b0;
      commit_cnt <= '0;
      err_addr <= 1'b0;
      err_short <= 1'b0;
    end else begin
      act_q <= frame_act;
      wr_pend <= last_rx & ~is_rd;
      if (cmd_rx) begin
        is_rd <= rx_byte[7];
        addr <= rx_byte[3:0];
        byte_cnt <= '0;
        hold <= rx_byte[7] ? rd_val : '0;
        tx_byte <= rx_byte[7] ? rd_val[FW_W-1 -: 8] : 8'h00;
      end
      // one shifter serves both directions: write bytes enter at the bottom, read bytes leave at the top
      if (data_rx) begin
        byte_cnt <= byte_cnt + 2'd1;
        hold <= {hold[FW_W-9:0], is_rd ? 8'h00 : rx_byte};
        tx_byte <= is_rd ? hold[FW_W-9 -: 8] : 8'h00;
      end
      sh_fw1 <= fw1_n;
      sh_fw2 <= fw2_n;
      sh_tri <= tri_n;
      ctrl <= ctrl_n;
      commit_pulse <= commit;
      if (commit) begin
        freq_word1 <= fw1_n;
        freq_word2 <= fw2_n;
        tri_sym2 <= tri_n;
        ch_en <= ctrl_n[1:0];
        commit_cnt <= commit_cnt + 8'd1;
      end
      err_addr <= (err_addr & ~stat_clr) | (cmd_rx & (rx_byte[3:0] > 4'd5));
      err_short <= (err_short & ~stat_clr) | short_end;
    end
  end
endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// tb_dds_cfg_ctrl: directed frame table, hand-timed corner sequences and random frames against a frame-level model
module tb_dds_cfg_ctrl;
  localparam logic [31:0] R = 32'd2147483;
  localparam logic [31:0] T = 32'd154748364;
  logic clk = 1'b0;
  logic rst, rx_valid, frame_act, commit_pulse;
  logic [7:0] rx_byte, tx_byte;
  logic [31:0] freq_word1, freq_word2, tri_sym2;
  logic [1:0] ch_en;
  int n_chk = 0, n_pass = 0, pulse_total = 0;
  logic [31:0] m_sh[3], m_act[3];
  logic [2:0] m_ctrl;
  logic [1:0] m_en;
  logic [7:0] m_cnt;
  logic m_ea, m_es;
  typedef struct {
    logic [7:0] cmd; logic [31:0] data; int nb; logic [31:0] rd;
    logic [31:0] fw1; logic [31:0] fw2; logic [1:0] en; int p;
  } vec_t;
  vec_t tbl[18];

  dds_cfg_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_act(frame_act),
    .tx_byte(tx_byte), .freq_word1(freq_word1), .freq_word2(freq_word2), .tri_sym2(tri_sym2),
    .ch_en(ch_en), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (commit_pulse === 1'b1) pulse_total <= pulse_total + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] tx);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tx = tx_byte;
    cyc(1);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] data, input int nb,
                           input logic [31:0] exp_rd, input int exp_p);
    logic [7:0] tx;
    logic [31:0] w, e;
    int p0;
    p0 = pulse_total;
    frame_act = 1'b1;
    cyc(2);
    send_byte(cmd, tx);
    check("tx_cmd", 32'(tx), 32'(exp_rd[31:24]));
    for (int i = 0; i < nb; i++) begin
      w = data << (8 * i);
      send_byte(w[31:24], tx);
      e = exp_rd << (8 * (i + 1));
      check("tx_data", 32'(tx), 32'(e[31:24]));
    end
    frame_act = 1'b0;
    cyc(4);
    check("commit_pulses", pulse_total - p0, exp_p);
  endtask

  task automatic check_reset();
    check("rst_fw1", freq_word1, R);
    check("rst_fw2", freq_word2, R);
    check("rst_tri", tri_sym2, T);
    check("rst_en", 32'(ch_en), 32'd3);
    check("rst_pulse", 32'(commit_pulse), 32'd0);
    check("rst_tx", 32'(tx_byte), 32'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = (k == 2) ? T : R;
      m_act[k] = m_sh[k];
    end
    m_ctrl = 3'b011;
    m_en = 2'b11;
    m_cnt = 8'd0;
    m_ea = 1'b0;
    m_es = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 32'd0;
    if (a < 3) v = m_sh[a];
    else if (a == 3) v = {29'b0, m_ctrl};
    else if (a == 5) v = {16'b0, m_cnt, 6'b0, m_ea, m_es};
    return v;
  endfunction

  // frame-level semantics: only what the whole frame achieves, not how the bytes are sequenced
  task automatic model_frame(input logic rd, input int a, input int nb, input logic [31:0] d, output int p);
    p = 0;
    if (a > 5) m_ea = 1'b1;
    if (nb < 4) m_es = 1'b1;
    else if (rd) begin
      if (a == 5) begin m_ea = 1'b0; m_es = 1'b0; end
    end else begin
      if (a < 3) m_sh[a] = d;
      else if (a == 3) m_ctrl = d[2:0];
      if (a == 4 || (a < 4 && m_ctrl[2])) begin
        for (int k = 0; k < 3; k++) m_act[k] = m_sh[k];
        m_en = m_ctrl[1:0];
        m_cnt++;
        p = 1;
      end
    end
  endtask

  initial begin
    logic [7:0] tx, cmd;
    logic [31:0] d, er;
    int a, nb, ep;
    logic rd;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; frame_act = 1'b0;
    cyc(2);
    check_reset();
    rst = 1'b0;
    cyc(2);
    tbl[0]  = '{8'h00, 32'h0A000000, 4, 32'h0, R, R, 2'b11, 0};
    tbl[1]  = '{8'h80, 32'h0, 4, 32'h0A000000, R, R, 2'b11, 0};
    tbl[2]  = '{8'h04, 32'h0, 4, 32'h0, 32'h0A000000, R, 2'b11, 1};
    tbl[3]  = '{8'h00, 32'h11111111, 4, 32'h0, 32'h0A000000, R, 2'b11, 0};
    tbl[4]  = '{8'h01, 32'h22222222, 4, 32'h0, 32'h0A000000, R, 2'b11, 0};
    tbl[5]  = '{8'h04, 32'h0, 4, 32'h0, 32'h11111111, 32'h22222222, 2'b11, 1};
    tbl[6]  = '{8'h85, 32'h0, 4, 32'h00000200, 32'h11111111, 32'h22222222, 2'b11, 0};
    tbl[7]  = '{8'h03, 32'h7, 4, 32'h0, 32'h11111111, 32'h22222222, 2'b11, 1};
    tbl[8]  = '{8'h01, 32'h12345678, 4, 32'h0, 32'h11111111, 32'h12345678, 2'b11, 1};
    tbl[9]  = '{8'h00, 32'hDEADBEEF, 2, 32'h0, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[10] = '{8'h85, 32'h0, 4, 32'h00000401, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[11] = '{8'h85, 32'h0, 4, 32'h00000400, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[12] = '{8'h81, 32'h0, 4, 32'h12345678, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[13] = '{8'h89, 32'h0, 4, 32'h0, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[14] = '{8'h85, 32'h0, 4, 32'h00000402, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[15] = '{8'h03, 32'h1, 4, 32'h0, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[16] = '{8'h83, 32'h0, 4, 32'h1, 32'h11111111, 32'h12345678, 2'b11, 0};
    tbl[17] = '{8'h04, 32'h0, 4, 32'h0, 32'h11111111, 32'h12345678, 2'b01, 1};
    for (int i = 0; i < 18; i++) begin
      run_frame(tbl[i].cmd, tbl[i].data, tbl[i].nb, tbl[i].rd, tbl[i].p);
      check("tbl_fw1", freq_word1, tbl[i].fw1);
      check("tbl_fw2", freq_word2, tbl[i].fw2);
      check("tbl_en", 32'(ch_en), 32'(tbl[i].en));
    end
    // commit edge timing: actives hold through the pending-write cycle, then change with the pulse
    run_frame(8'h00, 32'h55AA1234, 4, 32'h0, 0);
    frame_act = 1'b1;
    cyc(2);
    send_byte(8'h04, tx);
    for (int i = 0; i < 3; i++) send_byte(8'h00, tx);
    rx_byte = 8'h00; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("pre_commit_fw1", freq_word1, 32'h11111111);
    check("pre_commit_pulse", 32'(commit_pulse), 32'd0);
    cyc(1);
    check("commit_fw1", freq_word1, 32'h55AA1234);
    check("commit_pulse_hi", 32'(commit_pulse), 32'd1);
    cyc(1);
    check("commit_pulse_lo", 32'(commit_pulse), 32'd0);
    frame_act = 1'b0;
    cyc(3);
    // fourth byte arrives on the same cycle the frame ends
    frame_act = 1'b1;
    cyc(2);
    send_byte(8'h01, tx);
    send_byte(8'hCA, tx);
    send_byte(8'hFE, tx);
    send_byte(8'hF0, tx);
    rx_byte = 8'h0D; rx_valid = 1'b1; frame_act = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    cyc(3);
    check("edge_fw2_hold", freq_word2, 32'h12345678);
    run_frame(8'h04, 32'h0, 4, 32'h0, 1);
    check("edge_fw2", freq_word2, 32'hCAFEF00D);
    run_frame(8'h85, 32'h0, 4, 32'h00000700, 0);
    // reset in the middle of a write frame
    frame_act = 1'b1;
    cyc(2);
    send_byte(8'h00, tx);
    send_byte(8'h99, tx);
    rst = 1'b1; frame_act = 1'b0;
    cyc(2);
    check_reset();
    rst = 1'b0;
    cyc(2);
    model_reset();
    run_frame(8'h85, 32'h0, 4, 32'h0, 0);
    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : 4;
      d = $urandom;
      cmd = {rd, 3'($urandom_range(0, 7)), 4'(a)};
      er = rd ? model_read(a) : 32'd0;
      model_frame(rd, a, nb, d, ep);
      run_frame(cmd, d, nb, er, ep);
      check("rnd_fw1", freq_word1, m_act[0]);
      check("rnd_fw2", freq_word2, m_act[1]);
      check("rnd_tri", tri_sym2, m_act[2]);
      check("rnd_en", 32'(ch_en), 32'(m_en));
    end
    run_frame(8'h85, 32'h0, 4, model_read(5), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
